// File: rtl/sha_if_pkg.sv
// Shared definitions for the SHA host bridge: FSM encoding and bus-width legality.
package sha_if_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LACK = 3'd1,
    FACK = 3'd2,
    FEED = 3'd3,
    RUN  = 3'd4
  } state_t;

  function automatic bit bus_w_legal(input int w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

endpackage

// File: rtl/sha_host_if_if.sv
// Host-side beat bus of the SHA bridge: write/read pulses in, registered data and ack/err out.
interface sha_host_if_if #(parameter int BUS_W = 16) ();

  logic             load;
  logic             fetch;
  logic             first;
  logic [BUS_W-1:0] idata;
  logic [BUS_W-1:0] odata;
  logic             ack;
  logic             err;

  modport master (output load, fetch, first, idata, input  odata, ack, err);
  modport slave  (input  load, fetch, first, idata, output odata, ack, err);

endinterface

// File: rtl/sha_beat_pack.sv
// Packs BUS_W host beats into a block of 32-bit words; the first-loaded word ends up at index 0.
module sha_beat_pack #(
    parameter int BUS_W     = 16,
    parameter int BLK_WORDS = 16,
    parameter int IW        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [BUS_W-1:0] din,
    input  logic [IW-1:0]    rd_idx,
    output logic [31:0]      word_o
);

    localparam int W = BLK_WORDS * 32;

    logic [W-1:0] blk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        blk_q <= '0;
        else if (shift_en) blk_q <= {blk_q[W-BUS_W-1:0], din};
    end

    // Oldest data sits at the MSB end once the block is full.
    assign word_o = blk_q[(BLK_WORDS-1-int'(rd_idx))*32 +: 32];

endmodule

// File: rtl/sha_host_if.sv
// Host bridge for a SHA core: collects a message block beat by beat, streams it to the core,
// and serves the chaining value back to the host one beat per fetch.
module sha_host_if
    import sha_if_pkg::*;
#(
    parameter int BUS_W     = 16,
    parameter int BLK_WORDS = 16,
    parameter int DIG_WORDS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sha_host_if_if.slave            host,
    input  logic [32*DIG_WORDS-1:0] digest,
    input  logic                    core_busy,
    output logic [31:0]             msg_word,
    output logic                    msg_valid,
    output logic                    core_start,
    output logic                    core_first,
    output logic                    busy_valid,
    output logic                    blk_done
);

    localparam int BEATS  = BLK_WORDS * 32 / BUS_W;
    localparam int RBEATS = DIG_WORDS * 32 / BUS_W;
    localparam int BCW    = $clog2(BEATS);
    localparam int RCW    = $clog2(RBEATS);
    localparam int FCW    = $clog2(BLK_WORDS);

    if (!bus_w_legal(BUS_W)) begin : g_bad_bus_w
        $error("sha_host_if: BUS_W must be 8, 16 or 32");
    end

    state_t           state_q, state_d;
    logic [BCW-1:0]   beat_q, beat_d;
    logic [RCW-1:0]   rd_q, rd_d;
    logic [FCW-1:0]   feed_q, feed_d;
    logic [BUS_W-1:0] odata_q, odata_d;
    logic             err_q, err_d;
    logic             full_q, full_d;
    logic             first_q, first_d;
    logic             cfirst_q, cfirst_d;
    logic             cbusy_q;
    logic             shift_en;
    logic             fall;

    assign fall = cbusy_q & ~core_busy;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        rd_d     = rd_q;
        feed_d   = feed_q;
        odata_d  = odata_q;
        err_d    = 1'b0;
        full_d   = full_q;
        first_d  = first_q;
        cfirst_d = cfirst_q;
        shift_en = 1'b0;
        blk_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (host.load) begin
                    // Beat is captured with its load pulse so the host need not hold idata.
                    state_d  = LACK;
                    shift_en = 1'b1;
                    full_d   = (beat_q == BCW'(BEATS-1));
                    beat_d   = full_d ? '0 : beat_q + 1'b1;
                    if (beat_q == '0) first_d = host.first;
                    err_d    = host.fetch;
                end else if (host.fetch) begin
                    if (beat_q == '0) begin
                        state_d = FACK;
                        odata_d = digest[(RBEATS-1-int'(rd_q))*BUS_W +: BUS_W];
                        rd_d    = (rd_q == RCW'(RBEATS-1)) ? '0 : rd_q + 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            LACK: begin
                err_d  = host.load | host.fetch;
                feed_d = '0;
                if (full_q) begin
                    state_d  = FEED;
                    cfirst_d = first_q;
                end else begin
                    state_d  = IDLE;
                end
            end
            FACK: begin
                err_d   = host.load | host.fetch;
                state_d = IDLE;
            end
            FEED: begin
                err_d  = host.load | host.fetch;
                feed_d = feed_q + 1'b1;
                if (feed_q == FCW'(BLK_WORDS-1)) state_d = RUN;
            end
            RUN: begin
                err_d = host.load | host.fetch;
                if (fall) begin
                    blk_done = 1'b1;
                    rd_d     = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            rd_q     <= '0;
            feed_q   <= '0;
            odata_q  <= '0;
            err_q    <= 1'b0;
            full_q   <= 1'b0;
            first_q  <= 1'b0;
            cfirst_q <= 1'b0;
            cbusy_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rd_q     <= rd_d;
            feed_q   <= feed_d;
            odata_q  <= odata_d;
            err_q    <= err_d;
            full_q   <= full_d;
            first_q  <= first_d;
            cfirst_q <= cfirst_d;
            cbusy_q  <= core_busy;
        end
    end

    sha_beat_pack #(
        .BUS_W    (BUS_W),
        .BLK_WORDS(BLK_WORDS),
        .IW       (FCW)
    ) u_pack (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_en(shift_en),
        .din     (host.idata),
        .rd_idx  (feed_q),
        .word_o  (msg_word)
    );

    assign host.odata = odata_q;
    assign host.ack   = (state_q == LACK) || (state_q == FACK);
    assign host.err   = err_q;
    assign msg_valid  = (state_q == FEED);
    assign core_start = (state_q == FEED) && (feed_q == '0);
    assign core_first = cfirst_q;
    assign busy_valid = (state_q == FEED) || ((state_q == RUN) && !fall);

endmodule

// File: tb/tb_sha_host_if.sv
// Directed bench for sha_host_if: 16-bit and 32-bit/SHA-224 instances with scoreboarded word and beat checks.
module tb_sha_host_if;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // 16-bit, SHA-256 instance
    sha_host_if_if #(.BUS_W(16)) hif();
    logic [255:0] digest = '0;
    logic         core_busy = 1'b0;
    logic [31:0]  msg_word;
    logic         msg_valid, core_start, core_first, busy_valid, blk_done;

    sha_host_if #(.BUS_W(16), .BLK_WORDS(16), .DIG_WORDS(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .host(hif), .digest(digest), .core_busy(core_busy),
        .msg_word(msg_word), .msg_valid(msg_valid), .core_start(core_start),
        .core_first(core_first), .busy_valid(busy_valid), .blk_done(blk_done));

    // 32-bit, SHA-224 readout instance
    sha_host_if_if #(.BUS_W(32)) hif32();
    logic [223:0] digest32 = '0;
    logic         core_busy32 = 1'b0;
    logic [31:0]  msg_word32;
    logic         msg_valid32, core_start32, core_first32, busy_valid32, blk_done32;

    sha_host_if #(.BUS_W(32), .BLK_WORDS(16), .DIG_WORDS(7)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .host(hif32), .digest(digest32), .core_busy(core_busy32),
        .msg_word(msg_word32), .msg_valid(msg_valid32), .core_start(core_start32),
        .core_first(core_first32), .busy_valid(busy_valid32), .blk_done(blk_done32));

    logic [15:0] abc_beats [16] = '{16'hBA78, 16'h16BF, 16'h8F01, 16'hCFEA, 16'h4141, 16'h40DE,
                                    16'h5DAE, 16'h2223, 16'hB003, 16'h61A3, 16'h9617, 16'h7A9C,
                                    16'hB410, 16'hFF61, 16'hF200, 16'h15AD};
    logic [31:0] d224 [7] = '{32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
                              32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7};
    logic [255:0] dig_abc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic [31:0] exp_msg[$];
    logic [31:0] exp_msg32[$];
    logic [15:0] exp_rd[$];
    int msg_cnt = 0, feed_idx = 0, msg_cnt32 = 0, feed_idx32 = 0;
    logic [31:0] mw, mw32;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] abc_word(input int i);
        return (i == 0) ? 32'h61626380 : (i == 15) ? 32'h00000018 : 32'h0;
    endfunction

    function automatic logic [31:0] pat_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // Scoreboards for the streamed message words
    always @(negedge clk) begin
        if (msg_valid) begin
            if (exp_msg.size() == 0) chk("msg_unexpected", 1, 0);
            else begin
                mw = exp_msg.pop_front();
                chk("msg_word", msg_word, mw);
            end
            chk("core_start", core_start, (feed_idx == 0));
            chk("busy_valid_feed", busy_valid, 1);
            feed_idx = (feed_idx == 15) ? 0 : feed_idx + 1;
            msg_cnt++;
        end
        if (msg_valid32) begin
            if (exp_msg32.size() == 0) chk("msg32_unexpected", 1, 0);
            else begin
                mw32 = exp_msg32.pop_front();
                chk("msg_word32", msg_word32, mw32);
            end
            chk("core_start32", core_start32, (feed_idx32 == 0));
            feed_idx32 = (feed_idx32 == 15) ? 0 : feed_idx32 + 1;
            msg_cnt32++;
        end
    end

    task automatic load_a(input logic [15:0] d, input logic f);
        @(negedge clk);
        hif.load = 1'b1; hif.idata = d; hif.first = f;
        @(negedge clk);
        hif.load = 1'b0; hif.first = 1'b0;
        chk("load_ack", hif.ack, 1);
    endtask

    task automatic load_block_a(input bit alt, input logic f);
        logic [31:0] w;
        for (int i = 0; i < 16; i++) exp_msg.push_back(alt ? pat_word(i) : abc_word(i));
        for (int k = 0; k < 32; k++) begin
            w = alt ? pat_word(k / 2) : abc_word(k / 2);
            load_a((k % 2 == 1) ? w[15:0] : w[31:16], (k == 0) ? f : 1'b0);
        end
    endtask

    task automatic fetch_a(input logic [15:0] e);
        logic [15:0] x;
        exp_rd.push_back(e);
        @(negedge clk);
        hif.fetch = 1'b1;
        @(negedge clk);
        hif.fetch = 1'b0;
        x = exp_rd.pop_front();
        chk("fetch_ack", hif.ack, 1);
        chk("odata", hif.odata, x);
    endtask

    task automatic wait_start_a();
        int k = 0;
        while (!core_start && k < 40) begin @(negedge clk); k++; end
        chk("core_start_seen", core_start, 1);
    endtask

    task automatic finish_core_a();
        digest = dig_abc;
        core_busy = 1'b0;
        #1;
        chk("blk_done", blk_done, 1);
        chk("busy_valid_done", busy_valid, 0);
        @(negedge clk);
        chk("blk_done_pulse", blk_done, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {hif.ack, hif.err, hif.odata, msg_valid, core_start, core_first, busy_valid,
                  blk_done, msg_word}, '0);
    endtask

    initial begin
        hif.load = 0; hif.fetch = 0; hif.first = 0; hif.idata = '0;
        hif32.load = 0; hif32.fetch = 0; hif32.first = 0; hif32.idata = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        chk("reset_state32", {hif32.ack, hif32.err, hif32.odata, msg_valid32, busy_valid32}, '0);
        rst_n = 1'b1;

        // "abc" block, first block of a message
        load_block_a(1'b0, 1'b1);
        wait_start_a();
        chk("core_first", core_first, 1);
        core_busy = 1'b1;
        repeat (20) @(negedge clk);
        finish_core_a();
        chk("feed_count", msg_cnt, 16);
        chk("msg_queue_empty", exp_msg.size(), 0);

        for (int j = 0; j < 16; j++) fetch_a(abc_beats[j]);
        fetch_a(16'hBA78);

        // Second block; host traffic during RUN is rejected
        msg_cnt = 0;
        load_block_a(1'b1, 1'b0);
        wait_start_a();
        chk("core_first_cont", core_first, 0);
        core_busy = 1'b1;
        repeat (20) @(negedge clk);
        hif.load = 1'b1; hif.idata = 16'hFFFF;
        @(negedge clk);
        hif.load = 1'b0;
        chk("run_load_err", hif.err, 1);
        chk("run_load_ack", hif.ack, 0);
        chk("run_odata_hold", hif.odata, 16'hBA78);
        chk("run_buffer_hold", msg_word, pat_word(0));
        @(negedge clk);
        chk("err_pulse", hif.err, 0);
        finish_core_a();
        chk("feed_count2", msg_cnt, 16);
        for (int j = 0; j < 16; j++) fetch_a(abc_beats[j]);

        // Load and fetch together: load wins, fetch flagged
        @(negedge clk);
        hif.load = 1'b1; hif.fetch = 1'b1; hif.idata = 16'h6162; hif.first = 1'b1;
        @(negedge clk);
        hif.load = 1'b0; hif.fetch = 1'b0; hif.first = 1'b0;
        chk("both_ack", hif.ack, 1);
        chk("both_err", hif.err, 1);
        // Fetch with partial block
        @(negedge clk);
        hif.fetch = 1'b1;
        @(negedge clk);
        hif.fetch = 1'b0;
        chk("partial_fetch_err", hif.err, 1);
        chk("partial_fetch_ack", hif.ack, 0);
        chk("partial_odata_hold", hif.odata, 16'h15AD);
        for (int k = 1; k < 10; k++) load_a(16'h5A00 + 16'(k), 1'b0);

        // Asynchronous reset mid-load
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        msg_cnt = 0;
        load_block_a(1'b0, 1'b1);
        wait_start_a();
        chk("core_first_after_rst", core_first, 1);
        core_busy = 1'b1;
        repeat (20) @(negedge clk);
        finish_core_a();
        chk("feed_count3", msg_cnt, 16);
        fetch_a(16'hBA78);

        // 32-bit bus, SHA-224 readout
        for (int i = 0; i < 16; i++) exp_msg32.push_back(abc_word(i));
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            hif32.load = 1'b1; hif32.idata = abc_word(k); hif32.first = (k == 0);
            @(negedge clk);
            hif32.load = 1'b0; hif32.first = 1'b0;
            chk("load_ack32", hif32.ack, 1);
        end
        begin
            int k = 0;
            while (!core_start32 && k < 40) begin @(negedge clk); k++; end
            chk("core_start32_seen", core_start32, 1);
        end
        core_busy32 = 1'b1;
        repeat (20) @(negedge clk);
        digest32 = {d224[0], d224[1], d224[2], d224[3], d224[4], d224[5], d224[6]};
        core_busy32 = 1'b0;
        #1;
        chk("blk_done32", blk_done32, 1);
        @(negedge clk);
        chk("feed_count32", msg_cnt32, 16);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            hif32.fetch = 1'b1;
            @(negedge clk);
            hif32.fetch = 1'b0;
            chk("odata32", hif32.odata, d224[j % 7]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
